// File: rtl/adder_rr_arbiter.sv
// Shares one registered adder among NREQ requesters using a round-robin arbiter.
// Each result is returned in a single-entry output register tagged with the requester index.
module adder_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDW   = 2,
  parameter int WIDTH = 2,
  parameter int CNTW  = 16
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [WIDTH:0]        res_sum,
  output logic [IDW-1:0]        res_id,
  output logic [CNTW-1:0]       done_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          state, state_nx;
  logic [IDW-1:0]  ptr, grant, idx;
  logic            found, can_accept, accept, drain;
  logic [WIDTH-1:0] a_g, b_g;

  // Search starts one past the last winner; IDW-bit add wraps modulo NREQ.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = ptr + IDW'(k);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  assign can_accept = !res_valid || res_ready;
  assign accept     = !wb_rst_i && found && can_accept;
  assign drain      = res_valid && res_ready;
  assign a_g        = req_a[int'(grant)*WIDTH +: WIDTH];
  assign b_g        = req_b[int'(grant)*WIDTH +: WIDTH];

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant] = 1'b1;
  end

  // State register plus the datapath registers it qualifies.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= EMPTY;
      res_sum  <= '0;
      res_id   <= '0;
      done_cnt <= '0;
      ptr      <= IDW'(NREQ-1);
    end else begin
      state <= state_nx;
      if (accept) begin
        res_sum <= {1'b0, a_g} + {1'b0, b_g};
        res_id  <= grant;
        ptr     <= grant;
      end
      if (drain) done_cnt <= done_cnt + CNTW'(1);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      EMPTY: if (accept) state_nx = FULL;
      FULL:  if (drain && !accept) state_nx = EMPTY;
      default: state_nx = EMPTY;
    endcase
  end

  always_comb begin
    res_valid = (state == FULL);
  end

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed bench for adder_rr_arbiter: table-driven rotation and transfer vectors,
// plus hand-written backpressure, mid-transaction reset and counter-wrap sequences.
module tb_adder_rr_arbiter;
  localparam int NREQ = 4, IDW = 2, WIDTH = 2, CNTW = 4;

  logic                  wb_clk_i = 1'b0;
  logic                  wb_rst_i;
  logic [NREQ-1:0]       req_valid, req_ready;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic                  res_valid, res_ready;
  logic [WIDTH:0]        res_sum;
  logic [IDW-1:0]        res_id;
  logic [CNTW-1:0]       done_cnt;

  int n_tests = 0, n_fail = 0;

  adder_rr_arbiter #(.NREQ(NREQ), .IDW(IDW), .WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_id(res_id), .done_cnt(done_cnt)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    logic [3:0] valid;
    logic [7:0] a, b;
    logic       rdy;
    logic [3:0] exp_ready;
    logic       exp_rv;
    logic [2:0] exp_sum;
    logic [1:0] exp_id;
    logic [3:0] exp_cnt;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(logic [3:0] v, logic [7:0] a, logic [7:0] b, logic r,
                              logic [3:0] er, logic rv, logic [2:0] s, logic [1:0] id,
                              logic [3:0] c);
    vec_t t;
    t.valid = v; t.a = a; t.b = b; t.rdy = r; t.exp_ready = er;
    t.exp_rv = rv; t.exp_sum = s; t.exp_id = id; t.exp_cnt = c;
    return t;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic chk_res(input string tag, input int rv, input int s, input int id, input int c);
    chk({tag, " res_valid"}, res_valid, rv);
    chk({tag, " res_sum"}, res_sum, s);
    chk({tag, " res_id"}, res_id, id);
    chk({tag, " done_cnt"}, done_cnt, c);
  endtask

  initial begin
    // Rotation: requester i has a=i, b=1, so its sum is i+1.
    for (int k = 0; k < 8; k++)
      vecs[k] = mk(4'hF, 8'hE4, 8'h55, 1'b1, 4'(1 << (k % 4)), 1'b1,
                   3'((k % 4) + 1), 2'(k % 4), 4'(k));
    vecs[8]  = mk(4'h0, 8'h00, 8'h00, 1'b1, 4'h0, 1'b0, 3'd4, 2'd3, 4'd8);
    vecs[9]  = mk(4'h4, 8'h30, 8'h30, 1'b1, 4'h4, 1'b1, 3'd6, 2'd2, 4'd8);
    vecs[10] = mk(4'h0, 8'h00, 8'h00, 1'b1, 4'h0, 1'b0, 3'd6, 2'd2, 4'd9);

    // Reset held for two cycles with all requesters valid.
    wb_rst_i = 1'b1; req_valid = 4'hF; req_a = 8'hE4; req_b = 8'h55; res_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      chk("rst req_ready", req_ready, 0);
      chk_res("rst", 0, 0, 0, 0);
    end
    wb_rst_i = 1'b0;

    for (int k = 0; k < 11; k++) begin
      req_valid = vecs[k].valid; req_a = vecs[k].a; req_b = vecs[k].b; res_ready = vecs[k].rdy;
      #1;
      chk($sformatf("vec%0d req_ready", k), req_ready, vecs[k].exp_ready);
      step();
      chk_res($sformatf("vec%0d", k), vecs[k].exp_rv, vecs[k].exp_sum, vecs[k].exp_id,
              vecs[k].exp_cnt);
    end

    // Backpressure: the last winner is 2, so requester 3 wins first (1+1=2).
    req_valid = 4'hA; req_a = 8'h48; req_b = 8'h44; res_ready = 1'b0;
    #1;
    chk("bp first req_ready", req_ready, 4'h8);
    step();
    chk_res("bp first", 1, 2, 3, 9);
    for (int c = 0; c < 5; c++) begin
      chk("bp hold req_ready", req_ready, 0);
      step();
      chk_res("bp hold", 1, 2, 3, 9);
    end
    res_ready = 1'b1;
    #1;
    chk("bp release req_ready", req_ready, 4'h2);
    step();
    chk_res("bp release", 1, 3, 1, 10);

    // Reset while a result is held under backpressure.
    res_ready = 1'b0; req_valid = 4'hF; req_a = 8'hE4; req_b = 8'h55; wb_rst_i = 1'b1;
    #1;
    chk("midrst req_ready", req_ready, 0);
    step();
    chk_res("midrst", 0, 0, 0, 0);
    wb_rst_i = 1'b0;
    #1;
    chk("postrst req_ready", req_ready, 4'h1);
    step();
    chk_res("postrst", 1, 1, 0, 0);

    // Counter wrap: continuous drain+refill, so res_valid must stay high throughout.
    res_ready = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      step();
      chk("wrap res_valid", res_valid, 1);
      chk("wrap done_cnt", done_cnt, c % 16);
      chk("wrap res_id", res_id, c % 4);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/adder_rr_arbiter.md
Name: adder_rr_arbiter

Overview:
Shares one registered WIDTH-bit adder between NREQ requesters in the user project area. Each requester presents an operand pair on a valid/ready handshake. A round-robin arbiter grants one requester per cycle. The sum is returned on a single-entry output register tagged with the granted requester's index. The block sits between GPIO/LA-driven requester logic and the adder datapath, and exposes a transaction counter for firmware visibility.

Parameters:
NREQ, 4, number of requesters; must be a power of 2, minimum 2.
IDW, 2, index width; must equal log2(NREQ).
WIDTH, 2, operand width; sum width is WIDTH+1.
CNTW, 16, width of the completed-transaction counter.

Ports:
wb_clk_i  input  1  single clock; all state updates on its rising edge.
wb_rst_i  input  1  synchronous, active-high reset.
req_valid  input  NREQ  per-requester request valid.
req_ready  output  NREQ  per-requester grant/accept, one-hot or zero.
req_a  input  NREQ*WIDTH  operand A; requester i uses bits [i*WIDTH +: WIDTH].
req_b  input  NREQ*WIDTH  operand B; same packing as req_a.
res_valid  output  1  result register holds a result.
res_ready  input  1  consumer accepts the result.
res_sum  output  WIDTH+1  a+b of the granted requester, zero-extended, never truncated.
res_id  output  IDW  index of the requester that produced res_sum.
done_cnt  output  CNTW  count of results consumed (res_valid & res_ready); wraps.

Behaviour:
- Reset: wb_rst_i is sampled on the clock edge only. Reset values:
  - res_valid=0, res_sum=0, res_id=0, done_cnt=0.
  - Priority pointer ptr=NREQ-1, so requester 0 has highest priority after reset.
  - req_ready=0 for the whole cycle in which wb_rst_i=1.
- can_accept = !res_valid | res_ready. This is a combinational path from res_ready to req_ready, by design.
- Arbitration (combinational):
  - Search req_valid starting at index (ptr+1) mod NREQ, ascending with wrap-around.
  - The first set bit is grant g.
  - req_ready[g] = can_accept. All other req_ready bits are 0.
  - No req_valid set means req_ready = 0.
- Accept: a transfer happens when req_valid[g] & req_ready[g]. On that edge:
  - res_sum <= zero-extended req_a[g] + req_b[g].
  - res_id <= g.
  - res_valid <= 1.
  - ptr <= g.
- Latency: one cycle from accept to res_valid=1 with the result.
- Throughput: one result per cycle while res_ready=1. Drain and refill in the same cycle is allowed.
- Drain without refill: res_valid & res_ready with no accept sets res_valid <= 0. res_sum and res_id hold their last value.
- Backpressure: while res_valid=1 and res_ready=0:
  - res_sum, res_id and res_valid are stable.
  - All req_ready bits are 0.
  - ptr is unchanged.
- Requester rules:
  - A requester must hold req_valid, req_a and req_b stable until accepted.
  - The arbiter makes no grant lock. g is recomputed every cycle from current req_valid, so a requester dropping valid early simply loses the slot.
- Fairness: with all requesters continuously valid and res_ready=1, grants rotate 0,1,2,3,0,... Each requester waits at most NREQ-1 grants.
- done_cnt increments by 1 on every res_valid & res_ready edge and wraps from 2^CNTW-1 to 0.
- Reset mid-transaction: an in-flight result is discarded (res_valid=0) and the pointer is reinitialised. No partial handshake survives reset.
- Two-state machine on res_valid:
  - EMPTY -> FULL on accept.
  - FULL -> FULL on drain+accept.
  - FULL -> EMPTY on drain without accept.
  - FULL -> FULL under backpressure.

Test Plan:
- Reset then idle: hold wb_rst_i=1 for 2 cycles with all req_valid=1 -> req_ready=0000, res_valid=0, done_cnt=0. After release, first grant goes to requester 0.
- Single transfer, max operands: requester 2 with a=3, b=3, res_ready=1 -> req_ready=0100 in the same cycle. Next cycle res_valid=1, res_sum=6, res_id=2. Following cycle done_cnt=1.
- Round-robin rotation: all four requesters valid with a=i, b=1, res_ready=1 for 8 cycles -> res_id sequence 0,1,2,3,0,1,2,3, res_sum sequence 1,2,3,4,..., one result per cycle.
- Backpressure: result held with res_ready=0 for 5 cycles while requesters 1 and 3 are valid -> req_ready=0000, res_sum/res_id stable, done_cnt unchanged. On res_ready=1, drain and accept occur in the same cycle, and the grant goes to the next index after the held res_id.
- Reset mid-operation: assert wb_rst_i while res_valid=1 and res_ready=0 -> next cycle res_valid=0, res_sum=0, done_cnt=0, and after release requester 0 has priority.
- Counter wrap: preset by running 2^CNTW consumes (use CNTW=4 in the bench) -> done_cnt goes 15 -> 0 with no glitch in res_valid.
